pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake on both sides.
- Splits a WIDTH-bit add into STAGES equal chunks, one chunk per pipeline stage, carry registered between stages.
- Sits between operand producers and result consumers in the datapath and replaces single-cycle combinational adders where timing fails at wide WIDTH.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES
STAGES, 4, pipeline depth; chunk width CHUNK = WIDTH/STAGES; STAGES >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; ignored when sub=1
sub  input  1  0: sum=a+b+cin; 1: sum=a-b (a+~b+1)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All stage valid bits, sum, cout, overflow and out_valid are 0 while rst_n=0. in_ready=1 one cycle after reset deassertion. Data registers other than valid bits need not be reset.
- Transfer on either side occurs on a rising edge with valid=1 and ready=1.
- Stage k (0..STAGES-1) holds valid[k], the partial sum bits [ (k+1)*CHUNK-1 : 0 ], the registered carry, and the not-yet-added upper operand bits. When sub=1, b is inverted and carry-in forced to 1 at the input of stage 0.
- Stage 0 adds chunk 0 with effective cin. Stage k adds chunk k with the carry from stage k-1.
- Last stage also registers overflow, computed from its MSB carry-in and carry-out.
- Per-stage ready: ready[k] = !valid[k] || ready[k+1]; ready[STAGES] = out_ready; in_ready = ready[0]. Bubbles collapse. No combinational path from in_valid to out_valid. out_ready reaches in_ready combinationally through the ready chain (accepted).
- Latency: STAGES cycles from input transfer to out_valid when not stalled. Throughput: 1 result/cycle with out_ready held high.
- Stall: while out_valid=1 and out_ready=0, sum/cout/overflow/out_valid hold stable. Upstream stages keep filling until full. Results are never dropped or duplicated, and order is preserved.
- Full: with all STAGES valid and out_ready=0, in_ready=0. When out_ready rises, in_ready=1 in the same cycle.
- Simultaneous output transfer and input transfer into a full pipe is allowed, and occupancy stays STAGES.
- Wrap-around: result is modulo 2^WIDTH; the lost bit appears on cout.
- STAGES=1 degenerates to a registered full-width adder with a 1-deep buffer: latency 1, in_ready = !out_valid || out_ready.
- Reset mid-operation: all in-flight results are discarded immediately. out_valid drops asynchronously.
- sub and cin are sampled only at input transfer and travel with the data.

Decomposition:
- No shared package entry needed beyond a localparam CHUNK = WIDTH/STAGES inside the module.
- Elaboration check: WIDTH % STAGES != 0 raises an $error.
- One natural sub-module: adder_stage (CHUNK-bit ripple-carry adder: inputs x, y, ci; outputs s, co, and carry into its MSB). Instantiated once per stage via generate.

Test Plan:
- Basic add, WIDTH=32, STAGES=4, out_ready=1: a=0x0000_0001, b=0x0000_FFFF, cin=0, sub=0 -> 4 cycles later sum=0x0001_0000, cout=0, overflow=0.
- Carry across all chunks: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, overflow=0. a=0x7FFF_FFFF, b=1, cin=0 -> sum=0x8000_0000, cout=0, overflow=1.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFF_FFFE, cout=0, overflow=0. a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, cout=1, overflow=1.
- Back-pressure: stream 10 operand pairs (i, i*3) with out_ready=0 -> in_ready falls after exactly 4 accepts. Release out_ready -> 10 results 4*i in order, none lost or duplicated, outputs stable during stall.
- Random stress: random in_valid/out_ready toggling over 10,000 transactions -> every result matches a reference model (a ± b + cin modulo 2^32, plus cout and overflow) in order.
- Reset mid-stream: assert rst_n=0 with 3 results in flight -> out_valid=0 immediately. After release, in_ready=1 and the first new operand pair emerges alone after 4 cycles.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and configuration helpers for the pipelined adder/subtractor.
package pipelined_adder_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && (width % stages == 0);
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle: the producer/consumer side is master, the adder is slave.
interface pipelined_adder_if
   import pipelined_adder_pkg::*;
   #(parameter int WIDTH = DEF_WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );

endinterface

// File: rtl/pipelined_adder_stage.sv
// One chunk of ripple-carry addition; also exposes the carry into its MSB for overflow.
module adder_stage #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         cm
);

   logic [W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < W; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

   assign co = c[W];
   assign cm = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: WIDTH bits split into STAGES chunks, carry registered between chunks,
// valid/ready handshake with a per-stage ready chain so bubbles collapse.
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input logic               clk,
   input logic               rst_n,
   pipelined_adder_if.slave  bus
);

   localparam int CHUNK = WIDTH / STAGES;

   if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
   end

   logic [STAGES:0]                ready;
   logic [STAGES-1:0]              v_q, c_q, v_src, c_src, co, cm;
   logic [STAGES-1:0][WIDTH-1:0]   a_q, b_q, s_q;
   logic [STAGES-1:0][WIDTH-1:0]   a_src, b_src, s_src, s_nxt;
   logic [STAGES-1:0][CHUNK-1:0]   chunk_s;
   logic                           ovf_q;

   // Stage 0 takes operands from the bus (b pre-inverted for subtract); later stages from the previous register.
   always_comb begin
      ready         = '0;
      ready[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ready[k] = !v_q[k] || ready[k+1];
      end

      v_src    = '0;
      c_src    = '0;
      a_src    = '0;
      b_src    = '0;
      s_src    = '0;
      v_src[0] = bus.in_valid;
      c_src[0] = bus.sub | bus.cin;
      a_src[0] = bus.a;
      b_src[0] = bus.sub ? ~bus.b : bus.b;
      for (int k = 1; k < STAGES; k++) begin
         v_src[k] = v_q[k-1];
         c_src[k] = c_q[k-1];
         a_src[k] = a_q[k-1];
         b_src[k] = b_q[k-1];
         s_src[k] = s_q[k-1];
      end

      s_nxt = s_src;
      for (int k = 0; k < STAGES; k++) begin
         s_nxt[k][k*CHUNK +: CHUNK] = chunk_s[k];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      adder_stage #(.W(CHUNK)) u_add (
         .x  (a_src[k][k*CHUNK +: CHUNK]),
         .y  (b_src[k][k*CHUNK +: CHUNK]),
         .ci (c_src[k]),
         .s  (chunk_s[k]),
         .co (co[k]),
         .cm (cm[k])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ready[k]) begin
               v_q[k] <= v_src[k];
               if (v_src[k]) begin
                  a_q[k] <= a_src[k];
                  b_q[k] <= b_src[k];
                  s_q[k] <= s_nxt[k];
                  c_q[k] <= co[k];
               end
            end
         end
         if (ready[STAGES-1] && v_src[STAGES-1]) begin
            ovf_q <= cm[STAGES-1] ^ co[STAGES-1];
         end
      end
   end

   assign bus.in_ready  = ready[0];
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.sum       = s_q[STAGES-1];
   assign bus.cout      = c_q[STAGES-1];
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: expected results come from a plain-arithmetic model.
module tb_pipelined_adder;
   import pipelined_adder_pkg::*;

   localparam int W = 32;
   localparam int S = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(W)) bus ();

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           issue;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   n_acc  = 0;
   int   n_out  = 0;
   bit   lat_chk = 0;
   bit   stalled = 0;
   logic [W-1:0] h_sum;
   logic         h_cout, h_ovf;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
      end
   endtask

   // Reference: unsigned and signed results from 64-bit arithmetic.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t   e;
      longint sa, sb, sr, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         e.sum  = a - b;
         e.cout = (a >= b);
         sr     = sa - sb;
      end else begin
         ur     = longint'({32'b0, a}) + longint'({32'b0, b}) + longint'({63'b0, cin});
         e.sum  = ur[31:0];
         e.cout = ur[32];
         sr     = sa + sb + longint'({63'b0, cin});
      end
      e.ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      e.issue = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (stalled)
            chk("stall_hold", {bus.out_valid, bus.cout, bus.overflow, bus.sum},
                {1'b1, h_cout, h_ovf, h_sum});
         stalled = bus.out_valid && !bus.out_ready;
         h_sum   = bus.sum;
         h_cout  = bus.cout;
         h_ovf   = bus.overflow;
         if (bus.in_valid && bus.in_ready) begin
            e       = model(bus.a, bus.b, bus.cin, bus.sub);
            e.issue = cyc;
            q.push_back(e);
            n_acc++;
         end
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got sum %h, expected no output", bus.sum);
            end else begin
               e = q.pop_front();
               chk("result", {bus.cout, bus.overflow, bus.sum}, {e.cout, e.ovf, e.sum});
               if (lat_chk) chk("latency", cyc - e.issue, S);
            end
         end
      end else begin
         stalled = 0;
      end
   end

   // Called and returns at posedge+1; ok=1 if the operand set was accepted within budget cycles.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int budget, output bit ok);
      bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain", q.size(), 0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom();
      endcase
   endfunction

   logic [W-1:0] va [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005,
                            32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0000};
   logic [W-1:0] vb [8] = '{32'h0000_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0007,
                            32'h0000_0001, 32'h8765_4321, 32'hFFFF_FFFF, 32'h0000_0001};
   logic         vc [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic         vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

   bit ok;
   bit done = 0;
   int acc0, out0;

   initial begin
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.out_ready = 1'b0;

      #12;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sum", bus.sum, 0);
      chk("rst_cout", bus.cout, 0);
      chk("rst_overflow", bus.overflow, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_rst", bus.in_ready, 1);

      // Directed vectors, back to back, unstalled.
      bus.out_ready = 1'b1;
      lat_chk = 1;
      for (int i = 0; i < 8; i++) begin
         send(va[i], vb[i], vc[i], vs[i], 4, ok);
         chk("directed_accept", ok, 1);
      end
      drain(20);

      // Back-pressure: pipe must fill after exactly S accepts.
      lat_chk = 0;
      bus.out_ready = 1'b0;
      acc0 = n_acc;
      out0 = n_out;
      for (int i = 0; i < 4; i++) begin
         send(W'(i), W'(i * 3), 1'b0, 1'b0, 1, ok);
         chk("fill_accept", ok, 1);
      end
      bus.a = W'(4); bus.b = W'(12); bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("full_in_ready", bus.in_ready, 0);
      chk("full_accepts", n_acc - acc0, 4);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      #1 chk("in_ready_follows_out_ready", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 5; i < 10; i++) begin
         send(W'(i), W'(i * 3), 1'b0, 1'b0, 4, ok);
         chk("bp_accept", ok, 1);
      end
      drain(20);
      chk("bp_accepts", n_acc - acc0, 10);
      chk("bp_outputs", n_out - out0, 10);

      // Random stress with independent producer and consumer throttling.
      acc0 = n_acc;
      out0 = n_out;
      fork
         begin
            for (int t = 0; t < 10000; t++) begin
               if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
               send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 200, ok);
               if (!ok) begin
                  chk("random_accept_timeout", ok, 1);
                  break;
               end
            end
            done = 1;
         end
         begin
            while (!done) begin
               bus.out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      bus.out_ready = 1'b1;
      drain(50);
      chk("random_outputs", n_out - out0, n_acc - acc0);

      // Reset with results in flight.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(W'(100 + i), W'(1), 1'b0, 1'b0, 1, ok);
         chk("inflight_accept", ok, 1);
      end
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_reset_out_valid", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1 chk("reset_drops_out_valid", bus.out_valid, 0);
      q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("in_ready_after_midreset", bus.in_ready, 1);
      lat_chk = 1;
      out0 = n_out;
      send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1, ok);
      chk("post_reset_accept", ok, 1);
      repeat (10) begin @(posedge clk); #1; end
      chk("post_reset_single", n_out - out0, 1);
      chk("post_reset_drain", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
